// File: rtl/mux_sel_scheduler_if.sv
// Scheduler control/status bundle: enable and request lines in, mux select and strobes out.
// The master drives en/req; the slave (scheduler) drives the registered select side.
interface mux_sel_scheduler_if;
    logic       en;
    logic [3:0] req;
    logic [1:0] sel;
    logic       sel_valid;
    logic       slot_start;
    logic       wrap;

    modport master (
        output en,
        output req,
        input  sel,
        input  sel_valid,
        input  slot_start,
        input  wrap
    );

    modport slave (
        input  en,
        input  req,
        output sel,
        output sel_valid,
        output slot_start,
        output wrap
    );
endinterface

// File: rtl/mux_sel_scheduler.sv
// Round-robin TDM scheduler driving a 4x1 mux select, DWELL cycles per granted slot.
// Latency: 1 cycle from request (at a slot boundary) to registered select/strobes.
// Backpressure: none; en/req are only sampled at slot boundaries, a running slot always completes.
module mux_sel_scheduler #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mux_sel_scheduler_if.slave   sch
);
    typedef enum logic {S_IDLE, S_DWELL} state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       ptr_q;
    logic             have_prev_q;
    logic [1:0]       sel_q;
    logic             sel_valid_q;
    logic             slot_start_q;
    logic             wrap_q;

    logic [1:0]       pick;
    logic [1:0]       idx;
    logic             cnt_zero;
    logic             grant;

    assign cnt_zero = (cnt_q == '0);

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins;
    // offset 4 wraps back onto ptr itself, letting a lone requester be re-granted.
    always_comb begin
        pick = ptr_q;
        idx  = 2'b00;
        for (int i = 4; i >= 1; i--) begin
            idx = ptr_q + 2'(i);
            if (sch.req[idx]) begin
                pick = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sch.en && |sch.req) begin
                    grant   = 1'b1;
                    state_d = S_DWELL;
                end
            end
            S_DWELL: begin
                if (cnt_zero) begin
                    if (sch.en && |sch.req) begin
                        grant = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            ptr_q        <= 2'd3;
            have_prev_q  <= 1'b0;
            sel_q        <= 2'd0;
            sel_valid_q  <= 1'b0;
            slot_start_q <= 1'b0;
            wrap_q       <= 1'b0;
        end else begin
            slot_start_q <= grant;
            wrap_q       <= grant && have_prev_q && (pick <= ptr_q);
            if (grant) begin
                sel_q       <= pick;
                sel_valid_q <= 1'b1;
                ptr_q       <= pick;
                have_prev_q <= 1'b1;
                cnt_q       <= RELOAD;
            end else if (state_q == S_DWELL) begin
                // sel is deliberately left alone when the slot ends so the mux never glitches.
                if (cnt_zero) begin
                    sel_valid_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
        end
    end

    assign sch.sel        = sel_q;
    assign sch.sel_valid  = sel_valid_q;
    assign sch.slot_start = slot_start_q;
    assign sch.wrap       = wrap_q;
endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: a DWELL=4 and a DWELL=1 instance share stimulus and are
// checked every cycle against a slot-age model, plus hand-computed directed expectations.
module tb_mux_sel_scheduler;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [3:0] req;
    logic       chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    mux_sel_scheduler_if if4 ();
    mux_sel_scheduler_if if1 ();

    assign if4.en  = en;
    assign if4.req = req;
    assign if1.en  = en;
    assign if1.req = req;

    mux_sel_scheduler #(.DWELL(4), .CNT_W(8)) d4 (.clk(clk), .rst_n(rst_n), .sch(if4));
    mux_sel_scheduler #(.DWELL(1), .CNT_W(8)) d1 (.clk(clk), .rst_n(rst_n), .sch(if1));

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: per instance, slot age counts up from 0; a boundary is "no slot" or the last cycle of one.
    int dw     [2] = '{4, 1};
    bit m_act  [2];
    int m_age  [2];
    int m_last [2];
    bit m_prev [2];
    int m_sel  [2];
    bit m_vld  [2];
    bit m_ss   [2];
    bit m_wr   [2];

    always @(posedge clk or negedge rst_n) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                m_act[m] = 0; m_age[m] = 0; m_last[m] = 3; m_prev[m] = 0;
                m_sel[m] = 0; m_vld[m] = 0; m_ss[m] = 0; m_wr[m] = 0;
            end else if (!m_act[m] || m_age[m] == dw[m] - 1) begin
                if (en && req != 4'b0000) begin
                    int k;
                    k = -1;
                    for (int i = 1; i <= 4; i++) begin
                        if (k < 0 && req[(m_last[m] + i) % 4]) k = (m_last[m] + i) % 4;
                    end
                    m_wr[m]   = m_prev[m] && (k <= m_last[m]);
                    m_prev[m] = 1;
                    m_last[m] = k;
                    m_sel[m]  = k;
                    m_vld[m]  = 1;
                    m_ss[m]   = 1;
                    m_act[m]  = 1;
                    m_age[m]  = 0;
                end else begin
                    m_act[m] = 0; m_vld[m] = 0; m_ss[m] = 0; m_wr[m] = 0;
                end
            end else begin
                m_age[m]++;
                m_ss[m] = 0;
                m_wr[m] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("d4.sel",        int'(if4.sel),        m_sel[0]);
            check("d4.sel_valid",  int'(if4.sel_valid),  int'(m_vld[0]));
            check("d4.slot_start", int'(if4.slot_start), int'(m_ss[0]));
            check("d4.wrap",       int'(if4.wrap),       int'(m_wr[0]));
            check("d1.sel",        int'(if1.sel),        m_sel[1]);
            check("d1.sel_valid",  int'(if1.sel_valid),  int'(m_vld[1]));
            check("d1.slot_start", int'(if1.slot_start), int'(m_ss[1]));
            check("d1.wrap",       int'(if1.wrap),       int'(m_wr[1]));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect4(input string name, input int s, input int v, input int ss, input int w);
        check({name, ".sel"},   int'(if4.sel),        s);
        check({name, ".vld"},   int'(if4.sel_valid),  v);
        check({name, ".start"}, int'(if4.slot_start), ss);
        check({name, ".wrap"},  int'(if4.wrap),       w);
    endtask

    initial begin
        int seq6 [6];
        seq6 = '{1, 3, 0, 1, 3, 0};
        rst_n = 1'b0;
        en    = 1'b0;
        req   = 4'b0000;
        #2;
        expect4("reset", 0, 0, 0, 0);
        step(2);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(2);

        // 1: all channels request, rotate 0..3 with wrap only on return to 0.
        en  = 1'b1;
        req = 4'b1111;
        step(1); expect4("t1.g0", 0, 1, 1, 0);
        step(1); expect4("t1.mid", 0, 1, 0, 0);
        step(3); expect4("t1.g1", 1, 1, 1, 0);
        step(4); expect4("t1.g2", 2, 1, 1, 0);
        step(4); expect4("t1.g3", 3, 1, 1, 0);
        step(4); expect4("t1.g0b", 0, 1, 1, 1);

        // 2: channels 0 and 2 only.
        req = 4'b0101;
        step(4); expect4("t2.g2", 2, 1, 1, 0);
        step(4); expect4("t2.g0", 0, 1, 1, 1);
        step(12);

        // 3: lone requester ch3 is re-granted and wraps every slot.
        req = 4'b1000;
        step(4); expect4("t3.g3a", 3, 1, 1, 0);
        step(4); expect4("t3.g3b", 3, 1, 1, 1);
        step(4); expect4("t3.g3c", 3, 1, 1, 1);

        // 4: requests and enable vanish mid-slot; the slot still runs to completion.
        req = 4'b1111;
        step(4); expect4("t4.g0", 0, 1, 1, 1);
        step(1);
        req = 4'b0000;
        en  = 1'b0;
        step(2); expect4("t4.last", 0, 1, 0, 0);
        step(1); expect4("t4.idle", 0, 0, 0, 0);
        step(3); expect4("t4.hold", 0, 0, 0, 0);

        // 5: asynchronous reset in the middle of a ch2 slot.
        en  = 1'b1;
        req = 4'b0100;
        step(1); expect4("t5.g2", 2, 1, 1, 0);
        step(1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5.async.sel", int'(if4.sel), 0);
        check("t5.async.vld", int'(if4.sel_valid), 0);
        check("t5.async.d1vld", int'(if1.sel_valid), 0);
        step(2);
        rst_n = 1'b1;
        req   = 4'b1111;
        step(1); expect4("t5.first", 0, 1, 1, 0);

        // 6: DWELL=1 with req=1011 grants 1,3,0,... every cycle.
        req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check("t6.sel",   int'(if1.sel),        seq6[i]);
            check("t6.start", int'(if1.slot_start), 1);
            check("t6.wrap",  int'(if1.wrap),       (seq6[i] == 0) ? 1 : 0);
        end

        en = 1'b0;
        step(6);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
